// File: rtl/sqrt_post_scale.sv
// sqrt_post_scale
//   Post-processing for a hyperbolic-rotation square-root chain. The block
//   multiplies the chain's final X by its accumulated gain-correction
//   coefficient, scales the product back to Q1.(DSIZE-1) and saturates it.
//   It then undoes the even pre-normalisation shift that was applied to the
//   radicand.
//   The pipeline has three registered stages with a global stall and
//   valid/ready handshakes on both sides.
//
//   Build option: define SQRT_POST_ROUND_EN to round half-up in the scale
//   stage. When it is undefined the scale stage truncates.
//
// Ports
//   clock      in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream word present
//   in_ready   out  word accepted this cycle (combinational)
//   IX         in   [DSIZE-1:0] final X from rotation chain, unsigned Q1.(DSIZE-1)
//   K          in   [DSIZE-1:0] gain-correction coefficient, unsigned Q1.(DSIZE-1)
//   exp_shift  in   [4:0] even left-shift count applied to the radicand
//   out_valid  out  sqrt_out holds a result
//   out_ready  in   downstream accepts the result
//   sqrt_out   out  [DSIZE-1:0] corrected, denormalised square root
//   sat_cnt    out  [7:0] saturated results delivered, sticky at 255
module sqrt_post_scale #(
  parameter int DSIZE = 17
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] IX,
  input  logic [DSIZE-1:0] K,
  input  logic [4:0]       exp_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] sqrt_out,
  output logic [7:0]       sat_cnt
);

  localparam int PW = 2 * DSIZE;
  localparam int SW = DSIZE + 1;

  logic             adv;

  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_prod_q, s1_prod_d;
  logic [3:0]       s1_exp_q, s1_exp_d;

  logic [SW-1:0]    scaled;
  logic [SW-1:0]    scaled_rnd;
  logic             sat_now;

  logic             s2_valid_q, s2_valid_d;
  logic [DSIZE-1:0] s2_res_q, s2_res_d;
  logic             s2_sat_q, s2_sat_d;
  logic [3:0]       s2_exp_q, s2_exp_d;

  logic             s3_valid_q, s3_valid_d;
  logic [DSIZE-1:0] sqrt_out_q, sqrt_out_d;
  logic             s3_sat_q, s3_sat_d;

  logic [7:0]       sat_cnt_q, sat_cnt_d;

  // Only the shift amount is needed downstream, so the odd bit of exp_shift is
  // dropped. The product bits below the binary point feed at most the
  // rounding bit.
  logic unused_exp_lsb;
  logic unused_prod_lsbs;
  assign unused_exp_lsb   = exp_shift[0];
  assign unused_prod_lsbs = ^s1_prod_q[DSIZE-2:0];

  always_comb begin
    // The whole pipe moves together. An empty output slot, or one being
    // drained this cycle, lets every stage advance, and bubbles advance too.
    adv = !s3_valid_q || out_ready;

    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_exp_d   = s1_exp_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_sat_d   = s2_sat_q;
    s2_exp_d   = s2_exp_q;
    s3_valid_d = s3_valid_q;
    sqrt_out_d = sqrt_out_q;
    s3_sat_d   = s3_sat_q;
    sat_cnt_d  = sat_cnt_q;

    // Scale Q2.(2*DSIZE-2) back to Q1.(DSIZE-1), keeping one integer
    // overflow bit.
    scaled = s1_prod_q[PW-1:DSIZE-1];
`ifdef SQRT_POST_ROUND_EN
    scaled_rnd = scaled + SW'(s1_prod_q[DSIZE-2]);
`else
    scaled_rnd = scaled;
`endif
    sat_now = scaled_rnd[DSIZE];

    if (adv) begin
      s1_valid_d = in_valid;
      s1_prod_d  = PW'(IX) * PW'(K);
      s1_exp_d   = exp_shift[4:1];

      s2_valid_d = s1_valid_q;
      s2_res_d   = sat_now ? {DSIZE{1'b1}} : scaled_rnd[DSIZE-1:0];
      s2_sat_d   = sat_now;
      s2_exp_d   = s1_exp_q;

      s3_valid_d = s2_valid_q;
      sqrt_out_d = s2_res_q >> s2_exp_q;
      s3_sat_d   = s2_sat_q;
    end

    if (s3_valid_q && out_ready && s3_sat_q && (sat_cnt_q != 8'hFF))
      sat_cnt_d = sat_cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      sqrt_out_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      sqrt_out_q <= sqrt_out_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  // Data registers whose contents are qualified by the valid bits.
  always_ff @(posedge clock) begin
    s1_prod_q <= s1_prod_d;
    s1_exp_q  <= s1_exp_d;
    s2_res_q  <= s2_res_d;
    s2_sat_q  <= s2_sat_d;
    s2_exp_q  <= s2_exp_d;
    s3_sat_q  <= s3_sat_d;
  end

  assign in_ready  = adv;
  assign out_valid = s3_valid_q;
  assign sqrt_out  = sqrt_out_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sqrt_post_scale.sv
module tb_sqrt_post_scale;

  localparam int DSIZE = 17;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DSIZE-1:0] IX = '0;
  logic [DSIZE-1:0] K = '0;
  logic [4:0]       exp_shift = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DSIZE-1:0] sqrt_out;
  logic [7:0]       sat_cnt;

  int checks = 0;
  int errors = 0;

`ifdef SQRT_POST_ROUND_EN
  localparam logic [DSIZE-1:0] EXP_TINY = 17'h00002;
`else
  localparam logic [DSIZE-1:0] EXP_TINY = 17'h00001;
`endif

  sqrt_post_scale #(.DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IX        (IX),
    .K         (K),
    .exp_shift (exp_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sqrt_out  (sqrt_out),
    .sat_cnt   (sat_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Send one word with out_ready=1, then check the latency, the result and
  // the drain of the output slot.
  task automatic run_one(input string tag, input logic [DSIZE-1:0] ix, input logic [DSIZE-1:0] k,
                         input logic [4:0] sh, input logic [DSIZE-1:0] exp_val);
    int n;
    out_ready = 1'b1;
    IX = ix; K = k; exp_shift = sh; in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_data"}, 32'(sqrt_out), 32'(exp_val));
    step();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  logic [DSIZE-1:0] got_q[$];

  initial begin
    int acc;
    int cyc;
    int seen;

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sqrt_out", 32'(sqrt_out), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_one("unity", 17'h10000, 17'h10000, 5'd0, 17'h10000);
    run_one("half_k", 17'h08000, 17'h1279A, 5'd0, 17'h093CD);
    run_one("shift4", 17'h10000, 17'h10000, 5'd4, 17'h04000);
    run_one("shift5_odd", 17'h10000, 17'h10000, 5'd5, 17'h04000);
    run_one("tiny", 17'h00001, 17'h18000, 5'd0, EXP_TINY);
    check("sat_cnt_before", 32'(sat_cnt), 32'd0);
    run_one("sat", 17'h1FFFF, 17'h1FFFF, 5'd0, 17'h1FFFF);
    check("sat_cnt_one", 32'(sat_cnt), 32'd1);

    // 300 saturating words back to back: sat_cnt must stick at 255.
    acc = 0;
    cyc = 0;
    seen = 0;
    out_ready = 1'b1;
    IX = 17'h1FFFF; K = 17'h1FFFF; exp_shift = 5'd0;
    while ((acc < 300 || out_valid) && cyc < 1000) begin
      in_valid = (acc < 300);
      if (out_valid) seen++;
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_delivered", 32'(seen), 32'd300);
    check("stream_cycles", 32'(cyc), 32'd303);
    check("sat_cnt_sticky", 32'(sat_cnt), 32'd255);

    // Stall: five words offered with out_ready low; only three fit.
    out_ready = 1'b0;
    acc = 0;
    IX = 17'h10000; exp_shift = 5'd0;
    for (int i = 0; i < 6; i++) begin
      K = 17'(17'h01000 * (acc + 1));
      in_valid = (acc < 5);
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    check("stall_accepted", 32'(acc), 32'd3);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_hold_a", 32'(sqrt_out), 32'h01000);
    step();
    step();
    check("stall_hold_b", 32'(sqrt_out), 32'h01000);
    check("stall_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) got_q.push_back(sqrt_out);
      step();
    end
    check("stall_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size())
        check($sformatf("stall_order%0d", i), 32'(got_q[i]), 32'(17'h01000 * (i + 1)));

    // Reset with three words in flight.
    out_ready = 1'b0;
    IX = 17'h1FFFF; K = 17'h1FFFF;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("async_rst_sqrt_out", 32'(sqrt_out), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen++;
      step();
    end
    check("post_rst_no_stale", 32'(seen), 32'd0);
    run_one("post_rst_unity", 17'h10000, 17'h10000, 5'd2, 17'h08000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sqrt_post_scale.md
SQRT_POST_SCALE -- requirements
Module: sqrt_post_scale

Interface
REQ-001 DSIZE, 17, data width; all data is unsigned fixed point Q1.(DSIZE-1), so 2**(DSIZE-1) = 1.0.
REQ-002 clock  input  1  sole clock; all flops update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  the upstream hyperbolic-rotation chain presents a word this cycle.
REQ-005 in_ready  output  1  the block accepts the word this cycle.
REQ-006 IX  input  DSIZE  final X from the rotation chain, unsigned.
REQ-007 K  input  DSIZE  accumulated gain-correction coefficient from the chain.
REQ-008 exp_shift  input  5  even count of left shifts applied to the radicand before the chain.
REQ-009 out_valid  output  1  sqrt_out holds a valid result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sqrt_out  output  DSIZE  corrected, denormalised square root.
REQ-012 sat_cnt  output  8  count of saturated results, sticky at 255.

Function
REQ-013 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-014 Pipeline: three registered stages S1 multiply, S2 scale/saturate, S3 denormalise; each stage carries its own valid bit.
REQ-015 Stall: adv = !S3_valid || out_ready; all stages advance only when adv=1.
REQ-016 in_ready = adv (combinational); with no stall, latency from accept to out_valid is exactly 3 cycles, throughput 1/cycle.
REQ-017 S1: prod = IX*K, full 2*DSIZE bits, no truncation; S1 also registers exp_shift.
REQ-018 S2: scaled = prod >> (DSIZE-1), DSIZE+1 bits.
REQ-019 S2 saturation: if scaled >= 2**DSIZE, the result is 2**DSIZE-1 and sat_flag=1.
REQ-020 S3: sqrt_out = S2 result >> exp_shift[4:1]; exp_shift[0] is ignored.
REQ-021 sat_cnt increments by 1 on each out transfer whose word carries sat_flag, and holds at 255.
REQ-022 While out_valid=1 and out_ready=0, sqrt_out and out_valid are held stable.
REQ-023 A bubble (S_k valid=0) advances like data; results are never duplicated or dropped.
REQ-024 Simultaneous out transfer and in transfer in the same cycle are both honoured.

Reset
REQ-025 Reset, asserted asynchronously: all stage valids=0, out_valid=0, sqrt_out=0, sat_cnt=0.
REQ-026 In-flight words at reset are discarded; in_ready=1 in the first cycle after release.
REQ-027 Data-path registers other than sqrt_out may be left unreset.

Configuration
REQ-028 Macro SQRT_POST_ROUND_EN defined: S2 adds prod[DSIZE-2] to scaled (round-half-up) before the saturation check.
REQ-029 Macro SQRT_POST_ROUND_EN undefined: S2 truncates; no rounding adder is built.

Verification (DSIZE=17, 1.0 = 0x10000)
REQ-030 IX=0x10000, K=0x10000, exp_shift=0, out_ready=1 -> sqrt_out=0x10000, out_valid exactly 3 cycles after accept.
REQ-031 IX=0x08000, K=0x1279A, exp_shift=0 -> sqrt_out=0x093CD; with exp_shift=4 and IX=K=0x10000 -> 0x04000.
REQ-032 IX=0x1FFFF, K=0x1FFFF -> sqrt_out=0x1FFFF, sat_cnt goes 0 -> 1; 300 such words -> sat_cnt=255.
REQ-033 IX=0x00001, K=0x18000 -> sqrt_out=0x00002 with SQRT_POST_ROUND_EN, 0x00001 without.
REQ-034 out_ready=0, 5 back-to-back inputs -> 3 accepted then in_ready=0; release out_ready -> all accepted words delivered in order, none lost.
REQ-035 rst_n pulsed low with 3 words in flight -> out_valid falls immediately, sat_cnt=0, no stale word emitted after release.
